remote_comm: RTL
================

// Module: remote_comm
// PURPOSE
//  Host-side command transmitter: far end of the BLE/UART link that feeds cmd_proc's UART_wrapper.
//  Serializes one 16-bit command (2-bit veer/turn fields packed LSB-first) as two 8N1 UART frames.
//  Order: high byte cmd[15:8] first, then low byte cmd[7:0], back-to-back.
//  Reports completion with a held cmd_sent flag; used in the test harness and the remote controller.
// PARAMETERS
//  BAUD_DIV  2604  clk cycles per UART bit (50 MHz / 19200 baud); benches use 8.
// PORTS
//  clk       in   1   system clock, all state on rising edge
//  rst_n     in   1   asynchronous active-low reset
//  cmd       in   16  command word, sampled only on an accepted snd_cmd
//  snd_cmd   in   1   single-cycle request to transmit cmd
//  TX        out  1   serial line to BLE/UART_wrapper RX, idles high
//  busy      out  1   high while a command is in flight
//  cmd_sent  out  1   set when the low-byte stop bit completes; held until next accepted snd_cmd
// BEHAVIOUR
//  Reset (async, immediate): TX=1, busy=0, cmd_sent=0, FSM=IDLE, counters=0, capture reg=0.
//  Accept: snd_cmd sampled high at edge E0 while FSM==IDLE. Then:
//   cmd captured into cmd_reg; cmd_sent cleared; busy=1 from E0.
//  Ignore: snd_cmd while busy. No effect on cmd_reg, the frame in flight, or cmd_sent.
//  Frame timing, B=BAUD_DIV:
//   High-byte bit k (0=start '0', 1..8=data LSB first, 9=stop '1') drives TX over [E0+k*B, E0+(k+1)*B).
//   Low-byte bit k drives TX over [E0+(10+k)*B, E0+(11+k)*B).
//   No idle gap between the two frames.
//  Completion at edge E0+20*B: cmd_sent=1, busy=0, FSM=IDLE, TX stays 1.
//  Throughput: a snd_cmd sampled at edge E0+20*B is ignored (busy still high in the prior cycle).
//   The earliest acceptable request is at E0+20*B+1. Max rate is one command per 20*B+1 cycles.
//  Changing cmd after acceptance has no effect on the bits sent.
//  FSM states (in remote_comm):
//   IDLE -> HIGH on snd_cmd; issues trmt to uart_tx with cmd[15:8].
//   HIGH -> LOW on tx_done; issues trmt with cmd_reg[7:0] in the same cycle.
//   LOW  -> IDLE on tx_done; sets cmd_sent.
//  Reset mid-frame: TX returns to 1 asynchronously; the partial frame is abandoned; next accept starts fresh.
//  Baud counter width is $clog2(BAUD_DIV). Bit counter counts 0..9 and never wraps mid-frame.
// STRUCTURE
//  Shared package cmd_pkg:
//   localparam BAUD_DIV_DFLT=2604.
//   2-bit command field encodings, also imported by cmd_proc: STOP=2'b00, VEER_R=2'b01, VEER_L=2'b10, TURN=2'b11.
//   typedef enum logic[1:0] {IDLE,HIGH,LOW} rc_state_t.
//  One sub-module, uart_tx, owns byte framing.
//   Ports: clk, rst_n, trmt, tx_data[7:0], TX, tx_done.
//   10-bit shift register, baud counter, bit counter.
//   tx_done is a 1-cycle pulse in the final cycle of the stop bit.
//  remote_comm itself holds only the FSM, cmd_reg, and the cmd_sent/busy flops.
// TESTING
//  All tests use BAUD_DIV=8 and sample TX mid-bit.
//  T1, basic frame: cmd=16'hA5C3, snd_cmd @E0.
//   TX bits: 0,1,0,1,0,0,1,0,1,1 then 0,1,1,0,0,0,0,1,1,1.
//   busy=1 during [E0,E0+160); cmd_sent=1 @E0+160.
//  T2, loopback: TX->UART_wrapper RX, cmd=16'h01E7 -> cmd_rdy asserts with cmd==16'h01E7; no extra cmd_rdy.
//  T3, busy ignore: accept 16'h1234, pulse snd_cmd with cmd=16'hFFFF at E0+40.
//   Only 16'h1234 is received; cmd_sent rises once @E0+160.
//  T4, reset mid-frame: assert rst_n=0 at E0+50.
//   TX=1, busy=0, cmd_sent=0 immediately, with no clock edge needed.
//   After release, cmd 16'h00FF is sent and received intact.
//  T5, boundary timing:
//   snd_cmd held high through E0+160 -> ignored at E0+160, accepted at E0+161.
//   cmd_sent clears @E0+161 and the new start bit begins @E0+161.
//  T6, data extremes: 16'h0000 then 16'hFFFF.
//   Stop bits remain '1' and start bits remain '0'; the loopback receiver reports each word exactly.

Source files
------------

// File: rtl/cmd_pkg.sv
// Shared definitions for the command link: default baud divider, 2-bit command
// field encodings, and the transmitter FSM state type.
package cmd_pkg;

    localparam int BAUD_DIV_DFLT = 2604;

    localparam logic [1:0] STOP   = 2'b00;
    localparam logic [1:0] VEER_R = 2'b01;
    localparam logic [1:0] VEER_L = 2'b10;
    localparam logic [1:0] TURN   = 2'b11;

    typedef enum logic [1:0] {IDLE, HIGH, LOW} rc_state_t;

endpackage

// File: rtl/uart_tx.sv
// 8N1 UART byte transmitter: start bit, 8 data bits LSB first, stop bit.
// tx_done pulses in the last cycle of the stop bit; a trmt in that cycle chains the next byte.
module uart_tx #(
    parameter int BAUD_DIV = 2604
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       trmt,
    input  logic [7:0] tx_data,
    output logic       TX,
    output logic       tx_done
);

    localparam int CNT_W = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(BAUD_DIV - 1);

    logic [9:0]       shift_reg;
    logic [CNT_W-1:0] baud_cnt;
    logic [3:0]       bit_cnt;
    logic             sending;
    logic             bit_end;

    assign bit_end = sending && (baud_cnt == BAUD_LAST);
    assign tx_done = bit_end && (bit_cnt == 4'd9);
    // Ones are shifted in behind the frame, so the line rests high once the stop bit is out.
    assign TX      = shift_reg[0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_reg <= '1;
            baud_cnt  <= '0;
            bit_cnt   <= '0;
            sending   <= 1'b0;
        end else if (trmt) begin
            shift_reg <= {1'b1, tx_data, 1'b0};
            baud_cnt  <= '0;
            bit_cnt   <= '0;
            sending   <= 1'b1;
        end else if (tx_done) begin
            baud_cnt  <= '0;
            bit_cnt   <= '0;
            sending   <= 1'b0;
        end else if (bit_end) begin
            shift_reg <= {1'b1, shift_reg[9:1]};
            baud_cnt  <= '0;
            bit_cnt   <= bit_cnt + 4'd1;
        end else if (sending) begin
            baud_cnt  <= baud_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/remote_comm.sv
// Host-side command transmitter: sends a 16-bit command as two back-to-back UART
// frames (high byte first) and holds cmd_sent until the next accepted request.
module remote_comm
    import cmd_pkg::*;
#(
    parameter int BAUD_DIV = BAUD_DIV_DFLT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] cmd,
    input  logic        snd_cmd,
    output logic        TX,
    output logic        busy,
    output logic        cmd_sent
);

    rc_state_t  state;
    logic [7:0] cmd_reg;
    logic       accept;
    logic       trmt;
    logic       tx_done;
    logic [7:0] tx_data;

    // The high byte leaves straight from the input at acceptance; only the low byte is held.
    always_comb begin
        accept  = snd_cmd && (state == IDLE);
        trmt    = accept || ((state == HIGH) && tx_done);
        tx_data = accept ? cmd[15:8] : cmd_reg;
    end

    uart_tx #(
        .BAUD_DIV (BAUD_DIV)
    ) u_uart_tx (
        .clk      (clk),
        .rst_n    (rst_n),
        .trmt     (trmt),
        .tx_data  (tx_data),
        .TX       (TX),
        .tx_done  (tx_done)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cmd_reg  <= '0;
            busy     <= 1'b0;
            cmd_sent <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (snd_cmd) begin
                        cmd_reg  <= cmd[7:0];
                        cmd_sent <= 1'b0;
                        busy     <= 1'b1;
                        state    <= HIGH;
                    end
                end
                HIGH: begin
                    if (tx_done) state <= LOW;
                end
                LOW: begin
                    if (tx_done) begin
                        busy     <= 1'b0;
                        cmd_sent <= 1'b1;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
